// File: rtl/tpu_result_collector_if.sv
// tpu_result_collector_if
// Bundles the per-column result input stream and the row-vector output
// stream of the systolic-array result collector.
//   slave  : the collector's view (consumes columns, produces rows)
//   master : the surrounding environment's view
interface tpu_result_collector_if #(
  parameter int N      = 4,
  parameter int DATA_W = 16
);
  logic [N-1:0]        in_valid;
  logic [N*DATA_W-1:0] in_data;
  logic [N-1:0]        in_ready;
  logic                acc_en;
  logic                out_valid;
  logic                out_ready;
  logic [N*DATA_W-1:0] out_data;
  logic                out_last;
  logic                tile_done;
  logic                err;

  modport master (
    output in_valid, in_data, acc_en, out_ready,
    input  in_ready, out_valid, out_data, out_last, tile_done, err
  );

  modport slave (
    input  in_valid, in_data, acc_en, out_ready,
    output in_ready, out_valid, out_data, out_last, tile_done, err
  );
endinterface

// File: rtl/tpu_result_collector.sv
// tpu_result_collector
// Collects the skewed per-column result streams from the bottom edge of an
// NxN systolic array into a Q8.8 tile buffer, then streams the finished tile
// out one row vector per beat.
// Optional feature macro: RESULT_ACC_EN -- when defined, a tile started with
// acc_en=1 accumulates (saturating) into the existing buffer contents instead
// of overwriting them, enabling K-tiling across successive tiles.
module tpu_result_collector #(
  parameter int N       = 4,
  parameter int DATA_W  = 16,
  parameter int REVERSE = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  tpu_result_collector_if.slave bus
);

  localparam int CW = $clog2(N + 1);
  localparam int RW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FILL  = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  state_t                          state_r;
  state_t                          state_nxt_s;
  logic [N-1:0][CW-1:0]            cnt_r;
  logic [RW-1:0]                   row_r;
  logic [RW-1:0]                   row_nxt_s;
  // buf_r[row][col]; a row slice is already in out_data column order
  logic [N-1:0][N-1:0][DATA_W-1:0] buf_r;

  logic [N-1:0]                    in_ready_s;
  logic [N-1:0]                    accept_s;
  logic [N-1:0]                    drop_s;
  logic                            all_full_s;
  logic                            out_fire_s;
  logic                            last_fire_s;
  logic [N-1:0][RW-1:0]            wr_row_s;
  logic [N-1:0][DATA_W-1:0]        wr_data_s;

  logic                            out_valid_r;
  logic [N*DATA_W-1:0]             out_data_r;
  logic                            out_last_r;
  logic                            tile_done_r;
  logic                            err_r;

`ifdef RESULT_ACC_EN
  logic acc_mode_r;
  logic acc_eff_s;

  // Signed add with clamping to the most positive / most negative code.
  function automatic logic [DATA_W-1:0] sat_add(input logic [DATA_W-1:0] a,
                                                input logic [DATA_W-1:0] b);
    logic [DATA_W:0] sum;
    sum = {a[DATA_W-1], a} + {b[DATA_W-1], b};
    if (sum[DATA_W] != sum[DATA_W-1]) begin
      sat_add = sum[DATA_W] ? {1'b1, {(DATA_W-1){1'b0}}}
                            : {1'b0, {(DATA_W-1){1'b1}}};
    end else begin
      sat_add = sum[DATA_W-1:0];
    end
  endfunction
`endif

  // Per-column acceptance, drop detection and buffer write address/data.
  always_comb begin
    all_full_s = 1'b1;
`ifdef RESULT_ACC_EN
    // The very first beat of a tile uses acc_en directly; later beats use the latched mode.
    acc_eff_s = (state_r == ST_IDLE) ? bus.acc_en : acc_mode_r;
`endif
    for (int j = 0; j < N; j++) begin
      in_ready_s[j] = (state_r != ST_DRAIN) && (cnt_r[j] != CW'(N));
      accept_s[j]   = bus.in_valid[j] && in_ready_s[j];
      drop_s[j]     = bus.in_valid[j] && !in_ready_s[j];
      all_full_s    = all_full_s && (cnt_r[j] == CW'(N));
      if (REVERSE != 0) begin
        wr_row_s[j] = RW'(N - 1) - RW'(cnt_r[j]);
      end else begin
        wr_row_s[j] = RW'(cnt_r[j]);
      end
`ifdef RESULT_ACC_EN
      if (acc_eff_s) begin
        wr_data_s[j] = sat_add(buf_r[wr_row_s[j]][j], bus.in_data[j*DATA_W +: DATA_W]);
      end else begin
        wr_data_s[j] = bus.in_data[j*DATA_W +: DATA_W];
      end
`else
      wr_data_s[j] = bus.in_data[j*DATA_W +: DATA_W];
`endif
    end
    out_fire_s  = out_valid_r && bus.out_ready;
    last_fire_s = out_fire_s && (row_r == RW'(N - 1));
    row_nxt_s   = row_r + RW'(1);
  end

  // Next-state logic for the IDLE -> FILL -> DRAIN tile sequence.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE:  state_nxt_s = (|accept_s) ? ST_FILL : ST_IDLE;
      ST_FILL:  state_nxt_s = all_full_s ? ST_DRAIN : ST_FILL;
      ST_DRAIN: state_nxt_s = last_fire_s ? ST_IDLE : ST_DRAIN;
      default:  state_nxt_s = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Per-column fill counters; all clear when the last row leaves.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= '0;
    end else if (last_fire_s) begin
      cnt_r <= '0;
    end else begin
      for (int j = 0; j < N; j++) begin
        if (accept_s[j]) begin
          cnt_r[j] <= cnt_r[j] + CW'(1);
        end
      end
    end
  end

  // Tile buffer; only reset clears it, so accumulation can span tiles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_r <= '0;
    end else begin
      for (int j = 0; j < N; j++) begin
        if (accept_s[j]) begin
          buf_r[wr_row_s[j]][j] <= wr_data_s[j];
        end
      end
    end
  end

`ifdef RESULT_ACC_EN
  // Latch the accumulate mode on the first accepted beat of a tile.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_mode_r <= 1'b0;
    end else if ((state_r == ST_IDLE) && (|accept_s)) begin
      acc_mode_r <= bus.acc_en;
    end
  end
`endif

  // Registered row-vector output stream with row pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_r <= 1'b0;
      out_data_r  <= '0;
      out_last_r  <= 1'b0;
      row_r       <= '0;
    end else if ((state_r == ST_FILL) && all_full_s) begin
      out_valid_r <= 1'b1;
      out_data_r  <= buf_r[0];
      out_last_r  <= (N == 1);
      row_r       <= '0;
    end else if (last_fire_s) begin
      out_valid_r <= 1'b0;
      out_data_r  <= '0;
      out_last_r  <= 1'b0;
      row_r       <= '0;
    end else if (out_fire_s) begin
      out_data_r  <= buf_r[row_nxt_s];
      out_last_r  <= (row_nxt_s == RW'(N - 1));
      row_r       <= row_nxt_s;
    end
  end

  // One-cycle completion pulse and sticky drop error.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tile_done_r <= 1'b0;
      err_r       <= 1'b0;
    end else begin
      tile_done_r <= last_fire_s;
      err_r       <= err_r | (|drop_s);
    end
  end

  assign bus.in_ready  = in_ready_s;
  assign bus.out_valid = out_valid_r;
  assign bus.out_data  = out_data_r;
  assign bus.out_last  = out_last_r;
  assign bus.tile_done = tile_done_r;
  assign bus.err       = err_r;

endmodule
